// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and default constants for the data-memory arbiter.
// Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_MEM_DEPTH    = 64;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  // Width needed to hold the values 0..limit inclusive.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : CPU, host and memory signal bundle around the arbiter.
//            host_lock exists only when DMEM_HOST_LOCK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
`ifdef DMEM_HOST_LOCK_EN
  logic              host_lock;
`endif

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              oob_err;

  modport slave (
`ifdef DMEM_HOST_LOCK_EN
    input  host_lock,
`endif
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output oob_err
  );

  modport master (
`ifdef DMEM_HOST_LOCK_EN
    output host_lock,
`endif
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  oob_err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module   : starve_counter
// Purpose  : Saturating count of consecutive denied host cycles.
// Revision : 1.0  initial release
// ============================================================================
module starve_counter
  import dmem_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic inc,
  input  wire logic clr,
  output logic      limit_reached
);

  localparam int CNT_W = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign limit_reached = (cnt_q == C_LIMIT);

  // Clear has priority so a grant and a denial can never both count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !limit_reached) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares single-port data memory between CPU (priority) and host,
//            with bounded host starvation. DMEM_HOST_LOCK_EN adds host_lock.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  wire logic     clk,
  input  wire logic     rst,
  dmem_arbiter_if.slave bus
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  owner_e            w_owner;
  logic              w_locked;
  logic              w_starve_max;
  logic              w_host_win;
  logic              w_own_req;
  logic              w_own_we;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_wdata;
  logic              w_in_range;
  logic              w_access;

  logic [DATA_W-1:0] host_rdata_q;
  logic [DATA_W-1:0] host_rdata_d;
  logic              host_rvalid_q;
  logic              host_rvalid_d;
  logic              oob_err_q;
  logic              oob_err_d;

  assign w_locked = (state_q == LOCKED);

  // rst is active-low: every grant is suppressed while it is held low.
  assign w_host_win = rst && bus.host_req &&
                      (w_locked || !bus.cpu_req || w_starve_max);

  // A lock keeps host ownership even on cycles without a host request.
  assign w_owner = (w_host_win || (rst && w_locked)) ? OWN_HOST : OWN_CPU;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk           (clk),
    .rst           (rst),
    .inc           (bus.host_req && !w_host_win),
    .clr           (w_host_win || !bus.host_req || w_locked),
    .limit_reached (w_starve_max)
  );

  always_comb begin
    w_own_req   = bus.cpu_req;
    w_own_we    = bus.cpu_we;
    w_own_addr  = bus.cpu_addr;
    w_own_wdata = bus.cpu_wdata;
    if (w_owner == OWN_HOST) begin
      w_own_req   = bus.host_req;
      w_own_we    = bus.host_we;
      w_own_addr  = bus.host_addr;
      w_own_wdata = bus.host_wdata;
    end
  end

  assign w_in_range = (w_own_addr < ADDR_W'(MEM_DEPTH));
  assign w_access   = rst && w_own_req;

  assign bus.mem_we    = w_access && w_own_we && w_in_range;
  assign bus.mem_addr  = w_own_addr;
  assign bus.mem_wdata = w_own_wdata;

  assign bus.host_gnt  = w_host_win;
  assign bus.cpu_stall = rst && bus.cpu_req && (w_owner == OWN_HOST);
  assign bus.cpu_rdata = (rst && bus.cpu_req && (w_owner == OWN_CPU) && w_in_range)
                         ? bus.mem_rdata : '0;

  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.oob_err     = oob_err_q;

  always_comb begin
    host_rdata_d  = host_rdata_q;
    host_rvalid_d = 1'b0;
    oob_err_d     = oob_err_q || (w_access && !w_in_range);
    if (w_host_win && !bus.host_we) begin
      host_rvalid_d = 1'b1;
      host_rdata_d  = w_in_range ? bus.mem_rdata : '0;
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef DMEM_HOST_LOCK_EN
    case (state_q)
      ARB:     if (w_host_win && bus.host_lock) state_d = LOCKED;
      LOCKED:  if (!bus.host_lock)              state_d = ARB;
      default: state_d = ARB;
    endcase
`else
    state_d = ARB;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ARB;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      oob_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      oob_err_q     <= oob_err_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the processor core's load/store path and a host port. The host port serves the boot preloader and debug reads/writes of data memory. Sits between `processor` and `data_mem`. It gives the CPU priority, bounds host starvation with a counter, and stalls the CPU on the cycles the host wins. It also returns host read data through a registered valid pulse.

Parameters:
ADDR_W, 32, width of word address on all ports (word index, not byte address)
DATA_W, 32, data width
MEM_DEPTH, 64, number of implemented words; addresses >= MEM_DEPTH are out of range
STARVE_LIMIT, 4, consecutive denied host cycles before host is forced a grant (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-low reset
cpu_req  in  1  CPU load/store this cycle
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load data, combinational
cpu_stall  out  1  hold PC/pipeline this cycle, combinational
host_req  in  1  host access request; hold req/we/addr/wdata stable until host_gnt
host_we  in  1  host write
host_addr  in  ADDR_W  host word address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host access performed this cycle, combinational
host_rdata  out  DATA_W  registered host read data
host_rvalid  out  1  one-cycle pulse, host_rdata valid
mem_we  out  1  data memory write enable
mem_addr  out  ADDR_W  data memory address
mem_wdata  out  DATA_W  data memory write data
mem_rdata  in  DATA_W  data memory combinational read data
oob_err  out  1  sticky out-of-range access flag

Behaviour:
- Reset (rst==0 at edge): starve_cnt=0, host_rdata=0, host_rvalid=0, oob_err=0, state=ARB.
- While rst==0: host_gnt=0, cpu_stall=0, mem_we=0, cpu_rdata=0.
- host_win = host_req && (!cpu_req || starve_cnt==STARVE_LIMIT). In state LOCKED, host_win = host_req.
- Grant rules:
  - host_gnt=host_win.
  - cpu_stall=cpu_req && host_win.
  - If host_win, the mem_* outputs are driven from the host_* inputs; otherwise from the cpu_* inputs.
  - mem_we = owner_we && owner_req && in_range.
- cpu_rdata = mem_rdata when the CPU owns the cycle and its address is in range; 0 otherwise. Zero CPU latency when not stalled.
- starve_cnt:
  - +1, saturating at STARVE_LIMIT, when host_req && !host_win.
  - Cleared to 0 when host_win or !host_req.
  - Forced to 0 in LOCKED.
- Host read: on a host_win && !host_we edge, host_rdata <= (in_range ? mem_rdata : 0) and host_rvalid <= 1. host_rvalid is otherwise 0. Read latency is 1 cycle after host_gnt.
- Out of range (addr >= MEM_DEPTH) on a granted access: write suppressed, read data 0, oob_err <= 1. oob_err stays set until reset.
- Simultaneous CPU and host access to the same address: only the owner accesses; the other side sees no effect that cycle.
- Reset mid-operation: a host read granted in the cycle rst samples low produces no host_rvalid. Any lock is dropped.
- FSM (2 states):
  - ARB: default.
  - ARB→LOCKED on an edge where host_win && host_lock (feature only).
  - LOCKED→ARB on an edge where host_lock==0.
  - Without the feature, the FSM stays in ARB permanently.

Optional Feature:
- Macro: DMEM_HOST_LOCK_EN.
- Defined: input port host_lock (1 bit) is added. In LOCKED the host owns memory every cycle, cpu_stall=cpu_req, and host_gnt=host_req; this is used for the burst preload after reset.
- Undefined: host_lock port is absent; behaviour is pure ARB arbitration.

Decomposition:
- Package dmem_pkg:
  - arb_state_e {ARB, LOCKED}.
  - Default constants for ADDR_W, DATA_W, MEM_DEPTH, STARVE_LIMIT.
  - Owner encoding (OWN_CPU, OWN_HOST).
- Sub-module starve_counter: saturating counter with inc/clr/limit-reached outputs. Everything else is flat in dmem_arbiter.

Test Plan:
1. mem[2]=8; CPU store addr 2 data 9, no host -> mem_we=1 same cycle, cpu_stall=0; later CPU load addr 2 returns 9.
2. cpu_req held every cycle, host read addr 0 (mem=6), STARVE_LIMIT=4 -> host denied 4 cycles; host_gnt=1 and cpu_stall=1 on the 5th; next cycle host_rvalid=1, host_rdata=6, starve_cnt=0.
3. CPU idle, host write addr 5 data 2 -> host_gnt=1 same cycle, mem_we=1; host_rvalid stays 0; subsequent CPU load addr 5 returns 2.
4. CPU store addr 64 (MEM_DEPTH=64) -> mem_we=0, oob_err=1 next cycle and held for 10 further cycles; clears only on rst=0.
5. Host read granted, rst=0 sampled that edge -> host_rvalid=0, host_rdata=0, starve_cnt=0 after reset.
6. (DMEM_HOST_LOCK_EN) host_lock=1 with 6 back-to-back writes to addr 0..5 while cpu_req=1 -> 6 consecutive host_gnt, cpu_stall=1 throughout; CPU resumes the cycle after host_lock drops.
